// File: rtl/intr_ctrl.sv
// Machine-level interrupt controller: software/timer pass-through plus edge-triggered
// external sources with a single-outstanding claim/complete handshake.
module intr_ctrl #(
    parameter int NumIrq       = 8,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ic_req_i,
    input  logic [AddressWidth-1:0]   ic_addr_i,
    input  logic                      ic_we_i,
    input  logic [DataWidth/8-1:0]    ic_be_i,
    input  logic [DataWidth-1:0]      ic_wdata_i,
    output logic                      ic_rvalid_o,
    output logic [DataWidth-1:0]      ic_rdata_o,
    output logic                      ic_err_o,
    input  logic                      timer_intr_i,
    input  logic [NumIrq-1:0]         ext_irq_i,
    output logic                      irq_software_o,
    output logic                      irq_timer_o,
    output logic                      irq_external_o,
    output logic [4:0]                irq_id_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_msip;
    logic                r_timer;
    logic [NumIrq-1:0]   r_enable;
    logic [NumIrq-1:0]   r_pending;
    logic [NumIrq-1:0]   r_ext_prev;
    logic [4:0]          r_in_service;
    logic [4:0]          w_in_service_next;

    logic [9:0]          w_off;
    logic                w_sel_msip, w_sel_pend, w_sel_enable, w_sel_claim, w_sel_status;
    logic                w_mapped, w_rd, w_wr;
    logic                w_claim_fire, w_complete;
    logic [4:0]          w_id;
    logic [NumIrq-1:0]   w_rise, w_clr;
    logic [DataWidth-1:0] w_be_mask, w_enable_ext, w_enable_merged;
    logic                w_unused;

    assign w_off        = ic_addr_i[9:0];
    assign w_unused     = ^ic_addr_i[AddressWidth-1:10];
    assign w_sel_msip   = (w_off == 10'h000);
    assign w_sel_pend   = (w_off == 10'h004);
    assign w_sel_enable = (w_off == 10'h008);
    assign w_sel_claim  = (w_off == 10'h00C);
    assign w_sel_status = (w_off == 10'h010);
    assign w_mapped     = w_sel_msip | w_sel_pend | w_sel_enable | w_sel_claim | w_sel_status;
    assign w_rd         = ic_req_i & ~ic_we_i;
    assign w_wr         = ic_req_i & ic_we_i;

    // Lowest index wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        w_id = '0;
        for (int i = NumIrq - 1; i >= 0; i--) begin
            if (r_pending[i] && r_enable[i]) begin
                w_id = 5'(i + 1);
            end
        end
    end

    assign w_claim_fire = w_rd & w_sel_claim & (r_state == IDLE) & (w_id != 5'd0);
    assign w_complete   = w_wr & w_sel_claim & ic_be_i[0] & (r_state == SERVICE)
                        & (ic_wdata_i[4:0] == r_in_service);
    assign w_rise       = ext_irq_i & ~r_ext_prev;

    genvar gi;
    generate
        for (gi = 0; gi < NumIrq; gi++) begin : g_clr
            assign w_clr[gi] = w_claim_fire & (w_id == 5'(gi + 1));
        end
        for (gi = 0; gi < DataWidth / 8; gi++) begin : g_be
            assign w_be_mask[gi*8 +: 8] = {8{ic_be_i[gi]}};
        end
    endgenerate

    assign w_enable_ext    = {{(DataWidth - NumIrq){1'b0}}, r_enable};
    assign w_enable_merged = (w_enable_ext & ~w_be_mask) | (ic_wdata_i & w_be_mask);

    always_comb begin
        w_state_next      = r_state;
        w_in_service_next = r_in_service;
        case (r_state)
            IDLE: begin
                if (w_claim_fire) begin
                    w_state_next      = SERVICE;
                    w_in_service_next = w_id;
                end
            end
            SERVICE: begin
                if (w_complete) begin
                    w_state_next      = IDLE;
                    w_in_service_next = '0;
                end
            end
            default: begin
                w_state_next      = IDLE;
                w_in_service_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_in_service <= '0;
            r_msip       <= 1'b0;
            r_timer      <= 1'b0;
            r_enable     <= '0;
            r_pending    <= '0;
            r_ext_prev   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_in_service <= w_in_service_next;
            r_timer      <= timer_intr_i;
            r_ext_prev   <= ext_irq_i;
            // A rise in the claim cycle re-arms the bit it clears.
            r_pending    <= (r_pending & ~w_clr) | w_rise;
            if (w_wr && w_sel_msip && ic_be_i[0]) begin
                r_msip <= ic_wdata_i[0];
            end
            if (w_wr && w_sel_enable) begin
                r_enable <= w_enable_merged[NumIrq-1:0];
            end
        end
    end

    always_comb begin
        ic_rdata_o = '0;
        ic_err_o   = 1'b0;
        if (ic_req_i) begin
            ic_err_o = ~w_mapped;
            if (w_rd) begin
                if (w_sel_msip)   ic_rdata_o = DataWidth'(r_msip);
                if (w_sel_pend)   ic_rdata_o = w_enable_ext & '0 | DataWidth'(r_pending);
                if (w_sel_enable) ic_rdata_o = w_enable_ext;
                if (w_sel_claim && r_state == IDLE) ic_rdata_o = DataWidth'(w_id);
                if (w_sel_status) ic_rdata_o = DataWidth'({r_state == SERVICE, 3'b000, r_in_service});
            end
        end
    end

    assign ic_rvalid_o    = ic_req_i;
    assign irq_software_o = r_msip;
    assign irq_timer_o    = r_timer;
    assign irq_id_o       = w_id;
    assign irq_external_o = (r_state == IDLE) && (w_id != 5'd0);

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: table-driven register vectors plus hand sequences,
// with bus responses checked through an expected-response queue.
module tb_intr_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ic_req_i = 1'b0;
    logic [31:0] ic_addr_i = '0;
    logic        ic_we_i = 1'b0;
    logic [3:0]  ic_be_i = '0;
    logic [31:0] ic_wdata_i = '0;
    logic        ic_rvalid_o;
    logic [31:0] ic_rdata_o;
    logic        ic_err_o;
    logic        timer_intr_i = 1'b0;
    logic [7:0]  ext_irq_i = '0;
    logic        irq_software_o, irq_timer_o, irq_external_o;
    logic [4:0]  irq_id_o;

    int checks = 0;
    int errors = 0;

    intr_ctrl #(.NumIrq(8), .DataWidth(32), .AddressWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_we_i(ic_we_i),
        .ic_be_i(ic_be_i), .ic_wdata_i(ic_wdata_i),
        .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o), .ic_err_o(ic_err_o),
        .timer_intr_i(timer_intr_i), .ext_irq_i(ext_irq_i),
        .irq_software_o(irq_software_o), .irq_timer_o(irq_timer_o),
        .irq_external_o(irq_external_o), .irq_id_o(irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Scoreboard side: every request cycle pops one expected response.
    always @(negedge clk_i) begin
        if (ic_req_i) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: response with no expected entry");
            end else begin
                e = sb_q.pop_front();
                if (ic_rvalid_o !== 1'b1 || ic_err_o !== e.err ||
                    (!e.we && ic_rdata_o !== e.rdata)) begin
                    errors++;
                    $display("FAIL %s: rvalid=%b err=%b rdata=%h expected rvalid=1 err=%b rdata=%h",
                             e.name, ic_rvalid_o, ic_err_o, ic_rdata_o, e.err, e.rdata);
                end else begin
                    $display("ok   %s: err=%b rdata=%h", e.name, ic_err_o, ic_rdata_o);
                end
            end
        end else begin
            checks++;
            if (ic_rvalid_o !== 1'b0 || ic_rdata_o !== 32'h0 || ic_err_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_bus: rvalid=%b rdata=%h err=%b expected all 0",
                         ic_rvalid_o, ic_rdata_o, ic_err_o);
            end
        end
    end

    // Called at posedge+1; drives one request cycle and returns at the next posedge+1.
    task automatic bus(input string nm, input logic we, input logic [9:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
        sb_q.push_back('{nm, we, er, ee});
        ic_req_i   = 1'b1;
        ic_we_i    = we;
        ic_addr_i  = {22'($urandom), addr};
        ic_be_i    = be;
        ic_wdata_i = wd;
        @(posedge clk_i);
        #1;
        ic_req_i   = 1'b0;
        ic_we_i    = 1'b0;
        ic_wdata_i = '0;
        ic_be_i    = '0;
    endtask

    task automatic rd(input string nm, input logic [9:0] addr, input logic [31:0] er);
        bus(nm, 1'b0, addr, 4'h0, 32'h0, er, 1'b0);
    endtask

    task automatic wr(input string nm, input logic [9:0] addr, input logic [31:0] wd);
        bus(nm, 1'b1, addr, 4'hF, wd, 32'h0, 1'b0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        tbl[0]  = '{"rst_status",   1'b0, 10'h010, 4'h0, 32'h0,       32'h0,   1'b0};
        tbl[1]  = '{"unmapped_rd",  1'b0, 10'h3FC, 4'h0, 32'h0,       32'h0,   1'b1};
        tbl[2]  = '{"rst_msip",     1'b0, 10'h000, 4'h0, 32'h0,       32'h0,   1'b0};
        tbl[3]  = '{"rst_enable",   1'b0, 10'h008, 4'h0, 32'h0,       32'h0,   1'b0};
        tbl[4]  = '{"en_wr_all",    1'b1, 10'h008, 4'hF, 32'h0000_01FF, 32'h0, 1'b0};
        tbl[5]  = '{"en_rd_masked", 1'b0, 10'h008, 4'h0, 32'h0,       32'hFF,  1'b0};
        tbl[6]  = '{"en_wr_be0",    1'b1, 10'h008, 4'h0, 32'h0,       32'h0,   1'b0};
        tbl[7]  = '{"en_rd_keep",   1'b0, 10'h008, 4'h0, 32'h0,       32'hFF,  1'b0};
        tbl[8]  = '{"en_wr_byte0",  1'b1, 10'h008, 4'h1, 32'hAAAA_000C, 32'h0, 1'b0};
        tbl[9]  = '{"en_rd_0c",     1'b0, 10'h008, 4'h0, 32'h0,       32'h0C,  1'b0};
        tbl[10] = '{"pend_wr_ign",  1'b1, 10'h004, 4'hF, 32'hFF,      32'h0,   1'b0};
        tbl[11] = '{"pend_rd_0",    1'b0, 10'h004, 4'h0, 32'h0,       32'h0,   1'b0};
        tbl[12] = '{"unmapped_wr",  1'b1, 10'h014, 4'hF, 32'h1,       32'h0,   1'b1};
        tbl[13] = '{"misalign_rd",  1'b0, 10'h002, 4'h0, 32'h0,       32'h0,   1'b1};
        tbl[14] = '{"claim_none",   1'b0, 10'h00C, 4'h0, 32'h0,       32'h0,   1'b0};
        tbl[15] = '{"status_idle",  1'b0, 10'h010, 4'h0, 32'h0,       32'h0,   1'b0};

        // Reset behaviour, asserted at time 0.
        #12;
        check("rst_irq_sw",  32'(irq_software_o), 32'h0);
        check("rst_irq_tmr", 32'(irq_timer_o),    32'h0);
        check("rst_irq_ext", 32'(irq_external_o), 32'h0);
        check("rst_irq_id",  32'(irq_id_o),       32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc(1);

        foreach (tbl[i]) begin
            bus(tbl[i].name, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata,
                tbl[i].exp_rdata, tbl[i].exp_err);
        end

        // Timer: one-cycle latency in both directions.
        timer_intr_i = 1'b1;
        check("tmr_not_yet", 32'(irq_timer_o), 32'h0);
        cyc(1);
        check("tmr_rise", 32'(irq_timer_o), 32'h1);
        timer_intr_i = 1'b0;
        check("tmr_hold", 32'(irq_timer_o), 32'h1);
        cyc(1);
        check("tmr_fall", 32'(irq_timer_o), 32'h0);

        // Software interrupt.
        wr("msip_set", 10'h000, 32'h1);
        check("sw_set", 32'(irq_software_o), 32'h1);
        rd("msip_rd1", 10'h000, 32'h1);
        wr("msip_clr", 10'h000, 32'h0);
        check("sw_clr", 32'(irq_software_o), 32'h0);

        // External: pulse line 3 then line 2 with ENABLE=0x0C.
        ext_irq_i = 8'h08; cyc(1);
        ext_irq_i = 8'h00; cyc(1);
        ext_irq_i = 8'h04; cyc(1);
        ext_irq_i = 8'h00; cyc(1);
        rd("pend_0c", 10'h004, 32'h0C);
        check("id_3", 32'(irq_id_o), 32'd3);
        check("ext_on", 32'(irq_external_o), 32'h1);
        rd("claim_3", 10'h00C, 32'd3);
        check("ext_off_svc", 32'(irq_external_o), 32'h0);
        rd("status_svc3", 10'h010, 32'h103);
        rd("pend_08", 10'h004, 32'h08);
        rd("claim_in_svc", 10'h00C, 32'h0);
        wr("complete_5", 10'h00C, 32'd5);
        rd("status_still3", 10'h010, 32'h103);
        wr("complete_3", 10'h00C, 32'd3);
        rd("status_idle2", 10'h010, 32'h0);
        check("id_4", 32'(irq_id_o), 32'd4);
        check("ext_on_4", 32'(irq_external_o), 32'h1);
        rd("claim_4", 10'h00C, 32'd4);
        wr("complete_4", 10'h00C, 32'd4);

        // Level held high: single pending set.
        wr("en_01", 10'h008, 32'h01);
        ext_irq_i = 8'h01;
        cyc(3);
        rd("pend_held", 10'h004, 32'h01);
        rd("claim_1", 10'h00C, 32'd1);
        cyc(10);
        rd("pend_no_repend", 10'h004, 32'h0);
        wr("complete_1", 10'h00C, 32'd1);
        cyc(4);
        rd("pend_still0", 10'h004, 32'h0);
        check("id_none_held", 32'(irq_id_o), 32'h0);
        ext_irq_i = 8'h00; cyc(1);
        ext_irq_i = 8'h01; cyc(1);
        ext_irq_i = 8'h00; cyc(1);
        rd("pend_rearm", 10'h004, 32'h01);

        // Disable hides a pending line but keeps the bit.
        wr("en_00", 10'h008, 32'h0);
        check("id_disabled", 32'(irq_id_o), 32'h0);
        check("ext_disabled", 32'(irq_external_o), 32'h0);
        rd("pend_kept", 10'h004, 32'h01);

        // Rise on the claimed line in the claim cycle: set wins.
        ext_irq_i = 8'h02; cyc(1);
        ext_irq_i = 8'h00; cyc(1);
        wr("en_02", 10'h008, 32'h02);
        check("id_2", 32'(irq_id_o), 32'd2);
        ext_irq_i = 8'h02;
        rd("claim_2_race", 10'h00C, 32'd2);
        ext_irq_i = 8'h00;
        rd("pend_race", 10'h004, 32'h03);
        rd("status_svc2", 10'h010, 32'h102);

        // Asynchronous reset in SERVICE.
        wr("msip_set2", 10'h000, 32'h1);
        timer_intr_i = 1'b1;
        cyc(1);
        check("pre_rst_sw",  32'(irq_software_o), 32'h1);
        check("pre_rst_tmr", 32'(irq_timer_o),    32'h1);
        check("pre_rst_id",  32'(irq_id_o),       32'd2);
        #1 rst_ni = 1'b0;
        #1;
        check("arst_sw",  32'(irq_software_o), 32'h0);
        check("arst_tmr", 32'(irq_timer_o),    32'h0);
        check("arst_id",  32'(irq_id_o),       32'h0);
        check("arst_ext", 32'(irq_external_o), 32'h0);
        timer_intr_i = 1'b0;
        cyc(2);
        rst_ni = 1'b1;
        cyc(1);
        rd("post_status", 10'h010, 32'h0);
        rd("post_pend",   10'h004, 32'h0);
        rd("post_enable", 10'h008, 32'h0);
        rd("post_msip",   10'h000, 32'h0);

        cyc(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
